// File: rtl/deslocador_sequencial.sv
// ----------------------------------------------------------------------------
// deslocador_sequencial
//
// Sequential shift unit. It takes a LARGURA-bit operand and a SHAMT_W-bit
// shift amount and performs SLL, SRL, SRA, ROL or ROR one bit position per
// clock. It talks to the multicycle control unit through an inicio/ocupado/
// pronto handshake.
//
// Ports:
//   clk      - system clock, every register updates on the rising edge
//   reset    - synchronous, active-high reset (highest priority)
//   inicio   - start request, accepted only while idle and not busy
//   tipo     - operation: 000 pass, 001 SLL, 010 SRL, 011 SRA, 100 ROL,
//              101 ROR, 110/111 pass
//   n_shift  - shift amount, from the shift-amount select mux
//   entrada  - operand, from the shift-source mux
//   saida    - result register, held until the next accepted start or reset
//   ocupado  - busy flag, covers the shifting and done cycles
//   pronto   - one-cycle done pulse
//
// Timing: with inicio sampled at edge k, the result sits in saida after edge
// k + n_shift, and pronto is high in the cycle after edge k + n_shift + 1.
// ocupado is high for n_shift + 1 cycles, ending with the pronto cycle.
// ----------------------------------------------------------------------------
module deslocador_sequencial #(
  parameter int LARGURA = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inicio,
  input  logic [2:0]         tipo,
  input  logic [SHAMT_W-1:0] n_shift,
  input  logic [LARGURA-1:0] entrada,
  output logic [LARGURA-1:0] saida,
  output logic               ocupado,
  output logic               pronto
);

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    DESLOCANDO = 2'b01,
    PRONTO     = 2'b10
  } estado_t;

  localparam logic [2:0] TIPO_SLL = 3'b001;
  localparam logic [2:0] TIPO_SRL = 3'b010;
  localparam logic [2:0] TIPO_SRA = 3'b011;
  localparam logic [2:0] TIPO_ROL = 3'b100;
  localparam logic [2:0] TIPO_ROR = 3'b101;

  localparam logic [SHAMT_W-1:0] CONT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CONT_UM   = {{(SHAMT_W-1){1'b0}}, 1'b1};

  estado_t            estado_r;
  logic [SHAMT_W-1:0] contador_r;
  logic [2:0]         tipo_r;
  logic [LARGURA-1:0] saida_r;
  logic               ocupado_r;
  logic               pronto_r;
  logic               aceita_s;

  // One-bit step of the latched operation; pass and reserved codes hold.
  function automatic logic [LARGURA-1:0] passo(input logic [2:0] op,
                                               input logic [LARGURA-1:0] v);
    logic [LARGURA-1:0] r;
    case (op)
      TIPO_SLL: r = {v[LARGURA-2:0], 1'b0};
      TIPO_SRL: r = {1'b0, v[LARGURA-1:1]};
      TIPO_SRA: r = {v[LARGURA-1], v[LARGURA-1:1]};
      TIPO_ROL: r = {v[LARGURA-2:0], v[LARGURA-1]};
      TIPO_ROR: r = {v[0], v[LARGURA-1:1]};
      default:  r = v;
    endcase
    return r;
  endfunction

  // ocupado and pronto are registered from the state, so they trail it by
  // one cycle. When the state has already gone back to OCIOSO, ocupado is
  // still high during the pronto cycle, and gating the start on it makes a
  // request in that cycle a no-op.
  assign aceita_s = inicio & ~ocupado_r;

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r   <= OCIOSO;
      contador_r <= CONT_ZERO;
      tipo_r     <= 3'b000;
      saida_r    <= {LARGURA{1'b0}};
      ocupado_r  <= 1'b0;
      pronto_r   <= 1'b0;
    end else begin
      ocupado_r <= (estado_r != OCIOSO);
      pronto_r  <= (estado_r == PRONTO);
      case (estado_r)
        OCIOSO: begin
          if (aceita_s) begin
            saida_r    <= entrada;
            contador_r <= n_shift;
            tipo_r     <= tipo;
            estado_r   <= (n_shift == CONT_ZERO) ? PRONTO : DESLOCANDO;
          end else begin
            estado_r <= OCIOSO;
          end
        end
        DESLOCANDO: begin
          saida_r <= passo(tipo_r, saida_r);
          // Guarded so the counter can never wrap below zero.
          if (contador_r != CONT_ZERO) begin
            contador_r <= contador_r - CONT_UM;
          end else begin
            contador_r <= CONT_ZERO;
          end
          if (contador_r <= CONT_UM) begin
            estado_r <= PRONTO;
          end else begin
            estado_r <= DESLOCANDO;
          end
        end
        PRONTO: begin
          estado_r <= OCIOSO;
        end
        default: begin
          estado_r <= OCIOSO;
        end
      endcase
    end
  end

  assign saida   = saida_r;
  assign ocupado = ocupado_r;
  assign pronto  = pronto_r;

endmodule

// File: tb/tb_deslocador_sequencial.sv
// ----------------------------------------------------------------------------
// tb_deslocador_sequencial
//
// Directed, self-checking bench for deslocador_sequencial. The inputs are
// driven on the falling edge and the outputs are sampled on the falling edge.
// Every expected value is a hand-computed constant.
// ----------------------------------------------------------------------------
module tb_deslocador_sequencial;

  logic        clk;
  logic        reset;
  logic        inicio;
  logic [2:0]  tipo;
  logic [4:0]  n_shift;
  logic [31:0] entrada;
  logic [31:0] saida;
  logic        ocupado;
  logic        pronto;

  int checks_total;
  int checks_passed;

  deslocador_sequencial #(
    .LARGURA(32),
    .SHAMT_W(5)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .inicio (inicio),
    .tipo   (tipo),
    .n_shift(n_shift),
    .entrada(entrada),
    .saida  (saida),
    .ocupado(ocupado),
    .pronto (pronto)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one operation and watch n+8 edges after the start edge. poke1 and
  // poke2 name loop edges after which a spurious start with junk operands is
  // driven for the following edge (-1 means none).
  task automatic run_op(input string tag, input logic [31:0] op,
                        input logic [4:0] n, input logic [2:0] t,
                        input logic [31:0] exp, input int poke1,
                        input int poke2);
    int first_pronto;
    int pr_cnt;
    int oc_cnt;
    first_pronto = -1;
    pr_cnt = 0;
    oc_cnt = 0;
    @(negedge clk);
    entrada = op;
    n_shift = n;
    tipo    = t;
    inicio  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    for (int e = 1; e <= int'(n) + 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (pronto === 1'b1) begin
        pr_cnt++;
        if (first_pronto < 0) first_pronto = e;
      end
      if (ocupado === 1'b1) oc_cnt++;
      if (e == poke1 || e == poke2) begin
        inicio  = 1'b1;
        entrada = 32'h1234_5678;
        n_shift = 5'd2;
        tipo    = 3'b010;
      end else begin
        inicio = 1'b0;
      end
    end
    check({tag, " latency"}, 32'(first_pronto), 32'(int'(n) + 1));
    check({tag, " pronto_pulses"}, 32'(pr_cnt), 32'd1);
    check({tag, " ocupado_cycles"}, 32'(oc_cnt), 32'(int'(n) + 1));
    check({tag, " saida"}, saida, exp);
  endtask

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Directed sequence.
  initial begin
    int pr_cnt;
    checks_total  = 0;
    checks_passed = 0;
    reset   = 1'b1;
    inicio  = 1'b0;
    tipo    = 3'b000;
    n_shift = 5'd0;
    entrada = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset saida", saida, 32'h0000_0000);
    check("reset ocupado", {31'd0, ocupado}, 32'd0);
    check("reset pronto", {31'd0, pronto}, 32'd0);
    reset = 1'b0;

    // SLL by 4.
    run_op("sll4", 32'h0000_0001, 5'd4, 3'b001, 32'h0000_0010, -1, -1);
    // SRA and SRL over the full range.
    run_op("sra31", 32'h8000_0000, 5'd31, 3'b011, 32'hFFFF_FFFF, -1, -1);
    run_op("srl31", 32'h8000_0000, 5'd31, 3'b010, 32'h0000_0001, -1, -1);
    // Rotates.
    run_op("ror1", 32'h0000_0001, 5'd1, 3'b101, 32'h8000_0000, -1, -1);
    run_op("rol4", 32'h8000_0001, 5'd4, 3'b100, 32'h0000_0018, -1, -1);
    // Zero shift amount.
    run_op("sll0", 32'hDEAD_BEEF, 5'd0, 3'b001, 32'hDEAD_BEEF, -1, -1);
    // Pass and reserved codes keep the operand but take the full latency.
    run_op("pass3", 32'hA5A5_0F0F, 5'd3, 3'b000, 32'hA5A5_0F0F, -1, -1);
    run_op("rsv7", 32'h1357_9BDF, 5'd2, 3'b111, 32'h1357_9BDF, -1, -1);
    // Busy protection: start at edge 4 while shifting, start at edge 10 in
    // the pronto cycle.
    run_op("busy", 32'h0000_00FF, 5'd8, 3'b001, 32'h0000_FF00, 3, 9);

    // Reset in the middle of a shift: SRL by 20, reset at the 5th shifting edge.
    @(negedge clk);
    entrada = 32'hFFFF_FFFF;
    n_shift = 5'd20;
    tipo    = 3'b010;
    inicio  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrst before saida", saida, 32'h0FFF_FFFF);
    check("midrst before ocupado", {31'd0, ocupado}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst saida", saida, 32'h0000_0000);
    check("midrst ocupado", {31'd0, ocupado}, 32'd0);
    check("midrst pronto", {31'd0, pronto}, 32'd0);
    reset = 1'b0;
    pr_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (pronto === 1'b1) pr_cnt++;
    end
    check("midrst no_pronto", 32'(pr_cnt), 32'd0);
    run_op("after_rst", 32'h0000_0003, 5'd1, 3'b001, 32'h0000_0006, -1, -1);

    // The result holds while idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold saida", saida, 32'h0000_0006);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
